ser9_parity_rx: RTL

//  Serial receiver feeding the team's 9-input XOR parity tree. Deserialises async frames
//  (start, 8 data LSB-first, parity, stop) into a 9-bit word a[8:0] = {parity, data[7:0]}.
//  The tree reduces the word; the result is registered as a parity-error flag.
//  The data byte is presented on a valid/ready interface with framing/overrun flags and a

---
 rtl/ser9_parity_rx_pkg.sv | 16 +
 rtl/ser9_baud_gen.sv | 32 +++
 rtl/ser9_xor9_tree.sv | 14 +
 rtl/ser9_parity_rx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ser9_parity_rx_pkg.sv
// Shared types and constants for the ser9 parity serial receiver.
// FSM encoding is 3 bits wide; a frame is start + 8 data + parity + stop.
package ser9_parity_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/ser9_baud_gen.sv
// Free-running bit-period counter with synchronous clear.
// mid_tick marks half a bit after a clear, bit_tick marks each full bit period.
module ser9_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic mid_tick_o,
    output logic bit_tick_o
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] MID_CNT = W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [W-1:0] BIT_CNT = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || cnt_q == BIT_CNT) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign mid_tick_o = (cnt_q == MID_CNT);
    assign bit_tick_o = (cnt_q == BIT_CNT);

endmodule

// File: rtl/ser9_xor9_tree.sv
// 9-input XOR reduction tree: three 3-input XORs folded by a final 3-input XOR.
module ser9_xor9_tree (
    input  logic [8:0] a,
    output logic       y
);

    logic [2:0] lvl1;

    assign lvl1[0] = a[0] ^ a[1] ^ a[2];
    assign lvl1[1] = a[3] ^ a[4] ^ a[5];
    assign lvl1[2] = a[6] ^ a[7] ^ a[8];
    assign y       = lvl1[0] ^ lvl1[1] ^ lvl1[2];

endmodule

// File: rtl/ser9_parity_rx.sv
// Serial frame receiver: deserialises {parity, data} into the XOR tree and
// presents the byte with parity/framing/overrun flags on a valid/ready port.
module ser9_parity_rx
    import ser9_parity_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit ODD_PARITY   = 1'b1,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 par_err,
    output logic                 frm_err,
    output logic                 ovr_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic sync1_q, sync2_q, rxd_s;
    rx_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [8:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic baud_clr, mid_tick, bit_tick, commit, xor_y, par_bad, cnt_inc;

    assign rxd_s = sync2_q;

    ser9_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (baud_clr),
        .mid_tick_o (mid_tick),
        .bit_tick_o (bit_tick)
    );

    ser9_xor9_tree u_xor (
        .a (shift_q),
        .y (xor_y)
    );

    assign par_bad = (xor_y != ODD_PARITY);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        baud_clr  = 1'b0;
        commit    = 1'b0;
        case (state_q)
            ST_IDLE: if (!rxd_s) begin
                state_d  = ST_START;
                baud_clr = 1'b1;
            end
            // Re-clearing at mid-start aligns every later bit_tick to mid-bit.
            ST_START: if (mid_tick) begin
                if (rxd_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_DATA;
                    baud_clr  = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: if (bit_tick) begin
                shift_d   = {rxd_s, shift_q[8:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
            end
            ST_PARITY: if (bit_tick) begin
                shift_d = {rxd_s, shift_q[8:1]};
                state_d = ST_STOP;
            end
            ST_STOP: if (bit_tick) begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        cnt_inc = 1'b0;
        if (valid_q && rx_ready) valid_d = 1'b0;
        // A commit on the accept edge wins over the clear above.
        if (commit) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q[7:0];
                perr_d  = par_bad;
                ferr_d  = ~rxd_s;
                valid_d = 1'b1;
                cnt_inc = par_bad | ~rxd_s;
            end else begin
                ovr_d   = 1'b1;
                cnt_inc = 1'b1;
            end
        end
        cnt_d = (cnt_inc && cnt_q != '1) ? cnt_q + ERR_CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= rxd;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign par_err   = perr_q;
    assign frm_err   = ferr_q;
    assign ovr_err   = ovr_q;
    assign err_count = cnt_q;

endmodule
